// File: rtl/fm_sb_pkg.sv
// Shared types for the spy-buffer playback path: monitor word, playback modes, FSM states.
package fm_sb_pkg;

   localparam int unsigned MON_DW_MAX    = 256;
   localparam int unsigned pb_mode_width = 2;

   typedef enum logic [pb_mode_width-1:0] {
      PB_OFF    = 2'b00,
      PB_SINGLE = 2'b01,
      PB_LOOP   = 2'b10
   } pb_mode_e;

   typedef struct packed {
      logic [MON_DW_MAX-1:0] fm_data;
      logic                  fm_vld;
   } fm_rt;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } pb_state_e;

endpackage

// File: rtl/fm_sb_rd_tag_pipe.sv
// Delay line marking which cycles carry valid memory read data.
module fm_sb_rd_tag_pipe #(
   parameter int unsigned RD_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tag_in,
   output logic tag_out
);

   logic [RD_LAT-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/fm_sb_playback.sv
// Spy-buffer playback: replays memory words onto the monitor path, or passes live data through.
module fm_sb_playback
   import fm_sb_pkg::*;
#(
   parameter int unsigned DW     = 256,
   parameter int unsigned AW     = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [pb_mode_width-1:0] pb_mode,
   input  logic                     pb_start,
   input  logic                     pb_stop,
   input  logic [AW-1:0]            pb_last_addr,
   input  logic [7:0]               pb_gap,
   output logic                     mem_rd_en,
   output logic [AW-1:0]            mem_rd_addr,
   input  logic [DW-1:0]            mem_rd_data,
   input  fm_rt                     fm_i,
   output fm_rt                     fm_o,
   output logic                     pb_busy,
   output logic                     pb_done,
   output logic [15:0]              pb_count
);

   localparam int unsigned IFW = $clog2(RD_LAT + 1);

   pb_state_e             state;
   logic                  loop_s;
   logic [AW-1:0]         last_s;
   logic [7:0]            gap_s;
   logic [7:0]            gap_cnt;
   logic [IFW-1:0]        inflight;
   logic                  tag_out;
   logic [MON_DW_MAX-1:0] rd_data_ext;

   assign rd_data_ext = MON_DW_MAX'(mem_rd_data);

   fm_sb_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (mem_rd_en),
      .tag_out (tag_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         fm_o        <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         pb_busy     <= 1'b0;
         pb_done     <= 1'b0;
         pb_count    <= '0;
         loop_s      <= 1'b0;
         last_s      <= '0;
         gap_s       <= '0;
         gap_cnt     <= '0;
         inflight    <= '0;
      end else begin
         // Reads issued minus words returned; zero means nothing left to drain.
         inflight <= inflight + IFW'(mem_rd_en) - IFW'(tag_out);
         pb_done  <= 1'b0;

         if (state == IDLE) begin
            fm_o <= fm_i;
         end else begin
            fm_o.fm_vld <= tag_out;
            if (tag_out) begin
               fm_o.fm_data <= rd_data_ext;
               if (pb_count != 16'hFFFF) pb_count <= pb_count + 16'd1;
            end
         end

         case (state)
            IDLE: begin
               if (pb_start && (pb_mode == PB_SINGLE || pb_mode == PB_LOOP)) begin
                  state       <= RUN;
                  pb_busy     <= 1'b1;
                  loop_s      <= (pb_mode == PB_LOOP);
                  last_s      <= pb_last_addr;
                  gap_s       <= pb_gap;
                  gap_cnt     <= '0;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= '0;
                  pb_count    <= '0;
               end
            end
            RUN: begin
               // mem_rd_en is precomputed one cycle ahead so the strobe leaves a flop.
               if (pb_stop || (mem_rd_en && !loop_s && mem_rd_addr == last_s)) begin
                  state     <= FLUSH;
                  mem_rd_en <= 1'b0;
               end else if (mem_rd_en) begin
                  mem_rd_addr <= (mem_rd_addr == last_s) ? '0 : mem_rd_addr + AW'(1);
                  gap_cnt     <= gap_s;
                  mem_rd_en   <= (gap_s == 8'd0);
               end else begin
                  gap_cnt   <= gap_cnt - 8'd1;
                  mem_rd_en <= (gap_cnt == 8'd1);
               end
            end
            FLUSH: begin
               if (inflight == '0) begin
                  state   <= DONE;
                  pb_done <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               pb_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fm_sb_playback.sv
// Randomized bench for fm_sb_playback against a read-schedule model of playback.
module tb_fm_sb_playback;
   import fm_sb_pkg::*;

   localparam int unsigned DW     = 256;
   localparam int unsigned AW     = 4;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam int unsigned MAXW   = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    pb_mode;
   logic          pb_start, pb_stop;
   logic [AW-1:0] pb_last_addr;
   logic [7:0]    pb_gap;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   fm_rt          fm_i, fm_o;
   logic          pb_busy, pb_done;
   logic [15:0]   pb_count;

   int n_checks = 0;
   int n_fail   = 0;

   fm_sb_playback #(
      .DW     (DW),
      .AW     (AW),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pb_mode      (pb_mode),
      .pb_start     (pb_start),
      .pb_stop      (pb_stop),
      .pb_last_addr (pb_last_addr),
      .pb_gap       (pb_gap),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .fm_i         (fm_i),
      .fm_o         (fm_o),
      .pb_busy      (pb_busy),
      .pb_done      (pb_done),
      .pb_count     (pb_count)
   );

   always #5 clk = ~clk;

   // Memory with RD_LAT read latency; garbage when no read is due.
   logic [DW-1:0] mem [DEPTH];
   logic          vpipe [RD_LAT];
   logic [AW-1:0] apipe [RD_LAT];

   always @(posedge clk) begin
      vpipe[0] <= mem_rd_en;
      apipe[0] <= mem_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         vpipe[i] <= vpipe[i-1];
         apipe[i] <= apipe[i-1];
      end
   end

   always_comb begin
      mem_rd_data = mem[apipe[RD_LAT-1]];
      if (!vpipe[RD_LAT-1]) mem_rd_data = ~mem[apipe[RD_LAT-1]];
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Pass-through with start pulses in modes 00/11 that must do nothing.
   task automatic passthru(input int n);
      fm_rt prev;
      bit   have;
      have = 1'b0;
      prev = '0;
      for (int i = 0; i < n; i++) begin
         if (have) begin
            check_eq("pt_vld", DW'(fm_o.fm_vld), DW'(prev.fm_vld));
            check_eq("pt_data", fm_o.fm_data, prev.fm_data);
            check_eq("pt_busy", DW'(pb_busy), '0);
            check_eq("pt_rd_en", DW'(mem_rd_en), '0);
         end
         pb_mode  = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
         pb_start = 1'($urandom_range(1));
         pb_stop  = 1'($urandom_range(1));
         fm_i     = {rand_word(), 1'($urandom_range(1))};
         prev     = fm_i;
         have     = 1'b1;
         @(negedge clk);
      end
      pb_start = 1'b0;
      pb_stop  = 1'b0;
   endtask

   // Model: reads every gap+1 cycles from rel 1, each word out RD_LAT+1 later,
   // FLUSH after the run ends, DONE once the last word is out.
   task automatic play(input logic [1:0] mode, input int last, input int gap, input int stop_rel,
                       input bit stop_at_start, input bit noise);
      bit            loop_m;
      bit            stopped;
      int            reads[$];
      int            r, k, r_last, end_run, flush_at, done_rel;
      bit            e_rd   [MAXW];
      int            e_addr [MAXW];
      bit            e_vld  [MAXW];
      logic [DW-1:0] e_data [MAXW];

      for (int i = 0; i < MAXW; i++) begin
         e_rd[i] = 0; e_addr[i] = 0; e_vld[i] = 0; e_data[i] = '0;
      end
      loop_m = (mode == 2'b10);
      k = 0;
      while (1) begin
         r = 1 + k * (gap + 1);
         if (!loop_m && k > last) break;
         if (stop_rel > 0 && r > stop_rel) break;
         reads.push_back(r);
         e_rd[r]                 = 1;
         e_addr[r]               = k % (last + 1);
         e_vld[r + RD_LAT + 1]   = 1;
         e_data[r + RD_LAT + 1]  = mem[k % (last + 1)];
         k++;
      end
      r_last   = reads[$];
      stopped  = (stop_rel > 0) && (loop_m || stop_rel < 1 + last * (gap + 1));
      end_run  = stopped ? stop_rel : r_last;
      flush_at = (end_run + 1 > r_last + RD_LAT + 1) ? end_run + 1 : r_last + RD_LAT + 1;
      done_rel = flush_at + 1;

      for (int rel = 0; rel <= done_rel + 1; rel++) begin
         if (rel > 0) begin
            check_eq("rd_en", DW'(mem_rd_en), DW'(e_rd[rel]));
            if (e_rd[rel]) check_eq("rd_addr", DW'(mem_rd_addr), DW'(e_addr[rel]));
            check_eq("fm_vld", DW'(fm_o.fm_vld), DW'(e_vld[rel]));
            if (e_vld[rel]) check_eq("fm_data", fm_o.fm_data, e_data[rel]);
            check_eq("busy", DW'(pb_busy), DW'(rel <= done_rel));
            check_eq("done", DW'(pb_done), DW'(rel == done_rel));
         end else begin
            check_eq("busy_idle", DW'(pb_busy), '0);
         end
         pb_start     = (rel == 0) || (noise && rel <= done_rel && $urandom_range(3) == 0);
         pb_stop      = (stop_rel > 0 && rel == stop_rel) || (rel == 0 && stop_at_start);
         pb_mode      = (rel == 0 || !noise) ? mode : 2'($urandom_range(3));
         pb_last_addr = (rel == 0) ? AW'(last) : AW'($urandom);
         pb_gap       = (rel == 0) ? 8'(gap) : 8'($urandom);
         fm_i         = {rand_word(), 1'($urandom_range(1))};
         if (rel == 0) begin
            // Start cycle is still IDLE, so this live word passes through.
            e_vld[1]  = fm_i.fm_vld;
            e_data[1] = fm_i.fm_data;
         end
         @(negedge clk);
      end
      pb_start = 1'b0;
      pb_stop  = 1'b0;
      pb_mode  = 2'b00;
      check_eq("count", DW'(pb_count), DW'(reads.size()));
   endtask

   initial begin
      rst          = 1'b1;
      pb_mode      = 2'b00;
      pb_start     = 1'b0;
      pb_stop      = 1'b0;
      pb_last_addr = '0;
      pb_gap       = '0;
      fm_i         = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

      @(negedge clk);
      @(negedge clk);
      check_eq("rst_fm_data", fm_o.fm_data, '0);
      check_eq("rst_fm_vld", DW'(fm_o.fm_vld), '0);
      check_eq("rst_rd_en", DW'(mem_rd_en), '0);
      check_eq("rst_rd_addr", DW'(mem_rd_addr), '0);
      check_eq("rst_busy", DW'(pb_busy), '0);
      check_eq("rst_done", DW'(pb_done), '0);
      check_eq("rst_count", DW'(pb_count), '0);
      rst = 1'b0;
      @(negedge clk);

      fm_i = {{32{8'hA5}}, 1'b1};
      @(negedge clk);
      check_eq("pt_a5_vld", DW'(fm_o.fm_vld), DW'(1));
      check_eq("pt_a5_data", fm_o.fm_data, {32{8'hA5}});
      passthru(20);

      play(2'b01, 3, 0, 0, 1'b0, 1'b0);
      play(2'b01, 1, 2, 0, 1'b0, 1'b0);
      play(2'b10, 2, 0, 14, 1'b0, 1'b0);
      play(2'b01, 0, 0, 0, 1'b1, 1'b1);
      play(2'b01, DEPTH - 1, 0, 0, 1'b0, 1'b1);
      play(2'b10, DEPTH - 1, 1, 40, 1'b0, 1'b1);
      passthru(5);

      // Reset at the second read drops everything in flight.
      pb_mode      = 2'b01;
      pb_last_addr = AW'(7);
      pb_gap       = 8'd0;
      pb_start     = 1'b1;
      @(negedge clk);
      pb_start = 1'b0;
      @(negedge clk);
      check_eq("mid_rd_en", DW'(mem_rd_en), DW'(1));
      check_eq("mid_rd_addr", DW'(mem_rd_addr), DW'(1));
      rst = 1'b1;
      #1;
      check_eq("mid_rst_rd_en", DW'(mem_rd_en), '0);
      check_eq("mid_rst_rd_addr", DW'(mem_rd_addr), '0);
      check_eq("mid_rst_busy", DW'(pb_busy), '0);
      check_eq("mid_rst_count", DW'(pb_count), '0);
      check_eq("mid_rst_vld", DW'(fm_o.fm_vld), '0);
      check_eq("mid_rst_data", fm_o.fm_data, '0);
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      pb_mode = 2'b00;
      for (int i = 0; i < 6; i++) begin
         check_eq("post_rst_done", DW'(pb_done), '0);
         check_eq("post_rst_busy", DW'(pb_busy), '0);
         @(negedge clk);
      end
      play(2'b01, 5, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
      for (int n = 0; n < 30; n++) begin
         bit lp;
         int st;
         lp = ($urandom_range(1) == 1);
         if (lp) st = int'($urandom_range(60, 1));
         else    st = ($urandom_range(1) == 1) ? int'($urandom_range(60, 1)) : 0;
         play(lp ? 2'b10 : 2'b01, int'($urandom_range(DEPTH - 1)), int'($urandom_range(3)), st,
              1'($urandom_range(1)), 1'b1);
         passthru(3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
